// File: rtl/npc_bus_pkg.sv
// Shared definitions for the memory-bus arbiter: FSM encoding, default bus
// widths and the grant-index width helper.
package npc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  // A single requester still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int mask_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first set bit of req
// scanning last+1, last+2, ... modulo NR_MASTER.
module rr_pick
  import npc_bus_pkg::*;
#(
  parameter  int NR_MASTER = 2,
  localparam int IW        = idx_w(NR_MASTER)
) (
  input  logic [NR_MASTER-1:0] req,
  input  logic [IW-1:0]        last,
  output logic [IW-1:0]        index,
  output logic                 found
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NR_MASTER) s = s - NR_MASTER;
    return IW'(s);
  endfunction

  logic [IW-1:0]        cand [NR_MASTER];
  logic [NR_MASTER-1:0] hit;

  for (genvar gi = 0; gi < NR_MASTER; gi++) begin : g_cand
    assign cand[gi] = wrap_add(last, gi + 1);
    assign hit[gi]  = req[cand[gi]];
  end

  // Walk backwards so the candidate closest to last+1 wins.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = NR_MASTER - 1; i >= 0; i--) begin
      if (hit[i]) begin
        index = cand[i];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory-bus slave among NR_MASTER requesters,
// one transaction at a time. Optional response watchdog: ARB_TIMEOUT_EN.
module bus_arbiter
  import npc_bus_pkg::*;
#(
  parameter int NR_MASTER = 2,
  parameter int ADDR_W    = BUS_ADDR_W,
  parameter int DATA_W    = BUS_DATA_W,
  parameter int TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NR_MASTER-1:0]          m_req_valid,
  output logic [NR_MASTER-1:0]          m_req_ready,
  input  logic [NR_MASTER*ADDR_W-1:0]   m_req_addr,
  input  logic [NR_MASTER-1:0]          m_req_wen,
  input  logic [NR_MASTER*DATA_W-1:0]   m_req_wdata,
  input  logic [NR_MASTER*DATA_W/8-1:0] m_req_wmask,
  output logic [NR_MASTER-1:0]          m_resp_valid,
  input  logic [NR_MASTER-1:0]          m_resp_ready,
  output logic [DATA_W-1:0]             m_resp_rdata,
  output logic                          s_req_valid,
  input  logic                          s_req_ready,
  output logic [ADDR_W-1:0]             s_req_addr,
  output logic                          s_req_wen,
  output logic [DATA_W-1:0]             s_req_wdata,
  output logic [DATA_W/8-1:0]           s_req_wmask,
  input  logic                          s_resp_valid,
  output logic                          s_resp_ready,
  input  logic [DATA_W-1:0]             s_resp_rdata,
  output logic                          arb_err
);

  localparam int IW = idx_w(NR_MASTER);
  localparam int MW = mask_w(DATA_W);

  arb_state_e    state_reg, state_next;
  logic [IW-1:0] grant_reg, grant_next;
  logic [IW-1:0] last_reg, last_next;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          resp_hs;
  logic          tmo_hit;

  logic [ADDR_W-1:0] addr_arr  [NR_MASTER];
  logic [DATA_W-1:0] wdata_arr [NR_MASTER];
  logic [MW-1:0]     wmask_arr [NR_MASTER];

  for (genvar gi = 0; gi < NR_MASTER; gi++) begin : g_unpack
    assign addr_arr[gi]  = m_req_addr[ADDR_W*gi +: ADDR_W];
    assign wdata_arr[gi] = m_req_wdata[DATA_W*gi +: DATA_W];
    assign wmask_arr[gi] = m_req_wmask[MW*gi +: MW];
  end

  // Payload is steered live from the granted master; nothing is latched.
  assign s_req_addr  = addr_arr[grant_reg];
  assign s_req_wen   = m_req_wen[grant_reg];
  assign s_req_wdata = wdata_arr[grant_reg];
  assign s_req_wmask = wmask_arr[grant_reg];

  rr_pick #(.NR_MASTER(NR_MASTER)) u_rr_pick (
    .req   (m_req_valid),
    .last  (last_reg),
    .index (pick_idx),
    .found (pick_found)
  );

  assign resp_hs = (state_reg == ST_RESP) && s_resp_valid && m_resp_ready[grant_reg];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt_reg, tmo_cnt_next;

  // A genuine response in the same cycle takes priority over the watchdog.
  assign tmo_hit = (state_reg == ST_RESP) && !resp_hs && (tmo_cnt_reg == CW'(TIMEOUT));

  always_comb begin
    tmo_cnt_next = tmo_cnt_reg;
    if (state_reg != ST_RESP) tmo_cnt_next = '0;
    else if (!resp_hs && !tmo_hit) tmo_cnt_next = tmo_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_reg <= '0;
    else     tmo_cnt_reg <= tmo_cnt_next;
  end
`else
  // Watchdog compiled out; TIMEOUT stays in the parameter list for a uniform interface.
  assign tmo_hit = (TIMEOUT < 0);
`endif

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    last_next    = last_reg;
    m_req_ready  = '0;
    m_resp_valid = '0;
    m_resp_rdata = '0;
    s_req_valid  = 1'b0;
    s_resp_ready = 1'b0;
    arb_err      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          state_next = ST_REQ;
          grant_next = pick_idx;
        end
      end
      ST_REQ: begin
        s_req_valid            = 1'b1;
        m_req_ready[grant_reg] = s_req_ready;
        if (s_req_ready) state_next = ST_RESP;
      end
      ST_RESP: begin
        s_resp_ready = m_resp_ready[grant_reg];
        if (tmo_hit) begin
          m_resp_valid[grant_reg] = 1'b1;
          arb_err                 = 1'b1;
          state_next              = ST_IDLE;
          last_next               = grant_reg;
        end else begin
          m_resp_valid[grant_reg] = s_resp_valid;
          m_resp_rdata            = s_resp_rdata;
          if (resp_hs) begin
            state_next = ST_IDLE;
            last_next  = grant_reg;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      last_reg  <= IW'(NR_MASTER - 1);
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// traffic against a transaction-ownership reference model.
module tb_bus_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int TMO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    m_req_valid = '0, m_req_wen = '0, m_resp_ready = '0;
  logic [N-1:0]    m_req_ready, m_resp_valid;
  logic [N*AW-1:0] m_req_addr  = '0;
  logic [N*DW-1:0] m_req_wdata = '0;
  logic [N*MW-1:0] m_req_wmask = '0;
  logic [DW-1:0]   m_resp_rdata;
  logic            s_req_valid, s_req_wen, s_resp_ready, arb_err;
  logic            s_req_ready = 1'b0, s_resp_valid = 1'b0;
  logic [AW-1:0]   s_req_addr;
  logic [DW-1:0]   s_req_wdata;
  logic [MW-1:0]   s_req_wmask;
  logic [DW-1:0]   s_resp_rdata = '0;

  bus_arbiter #(.NR_MASTER(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_wen(m_req_wen), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp_rdata(m_resp_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
    .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp_rdata(s_resp_rdata),
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Masters' pending requests and payloads.
  bit            pend    [N];
  logic [AW-1:0] p_addr  [N];
  logic          p_wen   [N];
  logic [DW-1:0] p_wdata [N];
  logic [MW-1:0] p_wmask [N];

  // Reference model: who owns the bus, and whether its request was accepted.
  bit            known     = 1'b0;
  int            owner     = -1;
  int            last      = N - 1;
  int            tcnt      = 0;
  bit            accepted  = 1'b0;
  bit            slv_busy  = 1'b0;
  logic [DW-1:0] slv_rdata = '0;
  bit            hs, tmo;
  int            dut_grants[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_next();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int n, idx;
    n = 0; idx = -1;
    for (int i = 0; i < N; i++) if (v[i] === 1'b1) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  // Drive master inputs from the bench arrays, then compare outputs to the model.
  task automatic sample();
    logic [N-1:0] oh;
    bit in_req, in_resp;
    for (int i = 0; i < N; i++) begin
      m_req_valid[i]             = pend[i];
      m_req_wen[i]               = p_wen[i];
      m_req_addr[AW*i +: AW]     = p_addr[i];
      m_req_wdata[DW*i +: DW]    = p_wdata[i];
      m_req_wmask[MW*i +: MW]    = p_wmask[i];
    end
    #1;
    in_req  = (owner >= 0) && !accepted;
    in_resp = (owner >= 0) && accepted;
    oh = '0;
    if (owner >= 0) oh[owner] = 1'b1;
    hs  = in_resp && s_resp_valid && m_resp_ready[owner];
    tmo = TMO_EN && in_resp && !hs && (tcnt == TMO);
    if (known) begin
      chk("s_req_valid", s_req_valid, in_req);
      chk("m_req_ready", m_req_ready, (in_req && s_req_ready) ? oh : '0);
      if (in_req) begin
        chk("s_req_addr", s_req_addr, p_addr[owner]);
        chk("s_req_wen", s_req_wen, p_wen[owner]);
        chk("s_req_wdata", s_req_wdata, p_wdata[owner]);
        chk("s_req_wmask", s_req_wmask, p_wmask[owner]);
      end
      chk("m_resp_valid", m_resp_valid, (in_resp && (s_resp_valid || tmo)) ? oh : '0);
      chk("s_resp_ready", s_resp_ready, in_resp ? m_resp_ready[owner] : 1'b0);
      if (in_resp && (s_resp_valid || tmo))
        chk("m_resp_rdata", m_resp_rdata, tmo ? '0 : s_resp_rdata);
      chk("arb_err", arb_err, tmo);
      if (s_req_valid && s_req_ready) dut_grants.push_back(onehot_idx(m_req_ready));
    end
  endtask

  // Advance the model across the rising edge, then wait for the next falling edge.
  task automatic advance();
    if (rst) begin
      owner = -1; accepted = 1'b0; last = N - 1; tcnt = 0; slv_busy = 1'b0; known = 1'b1;
    end else if (owner < 0) begin
      owner = rr_next();
      accepted = 1'b0;
    end else if (!accepted) begin
      if (s_req_ready) begin
        accepted = 1'b1; pend[owner] = 1'b0; tcnt = 0; slv_busy = 1'b1;
        slv_rdata = DW'($urandom);
      end
    end else if (hs || tmo) begin
      $display("txn master=%0d rdata=%h timeout=%0d t=%0t", owner, m_resp_rdata, tmo, $time);
      last = owner; owner = -1; slv_busy = 1'b0;
    end else begin
      tcnt++;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
    pend[i] = 1'b1; p_addr[i] = a; p_wen[i] = w; p_wdata[i] = d; p_wmask[i] = m;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    s_req_ready = 1'b0; s_resp_valid = 1'b0; m_resp_ready = '0;
    sample(); advance();
    rst = 1'b0;
    sample();
    chk("reset_outputs", {m_req_ready, m_resp_valid, s_req_valid, s_resp_ready, arb_err}, '0);
    advance();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int served;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; p_addr[i] = '0; p_wen[i] = 1'b0; p_wdata[i] = '0; p_wmask[i] = '0;
    end
    @(negedge clk);
    do_reset();

    // Single read from master 0 with a zero-wait slave.
    set_req(0, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
    s_req_ready = 1'b1; m_resp_ready = '1;
    sample(); chk("t1_c0_no_req", s_req_valid, 1'b0); advance();
    sample(); chk("t1_c1_req_valid", s_req_valid, 1'b1);
    chk("t1_c1_addr", s_req_addr, 32'h8000_0000); advance();
    s_resp_valid = 1'b1; s_resp_rdata = 32'h1234_5678;
    sample(); chk("t1_c2_resp_valid", m_resp_valid, 4'b0001);
    chk("t1_c2_rdata", m_resp_rdata, 32'h1234_5678); advance();
    s_resp_valid = 1'b0;
    sample(); advance();

    // Two masters requesting continuously must alternate.
    do_reset();
    dut_grants.delete();
    s_req_ready = 1'b1; m_resp_ready = '1;
    for (int c = 0; c < 13; c++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && !(owner == i && accepted))
          set_req(i, (i == 0) ? 32'h1000_0000 : 32'h2000_0000, 1'b0, 32'h0, 4'h0);
      s_resp_valid = slv_busy; s_resp_rdata = slv_rdata;
      sample(); advance();
    end
    chk("t2_grant_count", dut_grants.size() >= 4, 1'b1);
    for (int k = 0; k < 4; k++)
      chk("t2_grant_order", (k < dut_grants.size()) ? dut_grants[k] : -1, k % 2);

    // Master 1 write held off by the slave for 3 cycles.
    do_reset();
    set_req(1, 32'h3000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
    s_req_ready = 1'b0; m_resp_ready = '1;
    sample(); advance();
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("t3_hold_ready", m_req_ready, '0);
      chk("t3_hold_valid", s_req_valid, 1'b1);
      chk("t3_hold_wdata", s_req_wdata, 32'hDEAD_BEEF);
      advance();
    end
    s_req_ready = 1'b1;
    sample(); chk("t3_accept_ready", m_req_ready, 4'b0010); advance();
    s_resp_valid = 1'b1; s_resp_rdata = 32'h0;
    sample(); chk("t3_write_resp", m_resp_valid, 4'b0010); advance();
    s_resp_valid = 1'b0;

    // Response back-pressure from master 0 while master 1 waits.
    do_reset();
    set_req(0, 32'h4000_0000, 1'b0, 32'h0, 4'h0);
    set_req(1, 32'h5000_0000, 1'b0, 32'h0, 4'h0);
    s_req_ready = 1'b1; m_resp_ready = '1;
    sample(); advance();
    sample(); advance();
    s_resp_valid = 1'b1; s_resp_rdata = 32'hCAFE_0001; m_resp_ready = 4'b1110;
    for (int c = 0; c < 2; c++) begin
      sample();
      chk("t4_bp_s_resp_ready", s_resp_ready, 1'b0);
      chk("t4_bp_no_grant", s_req_valid, 1'b0);
      advance();
    end
    m_resp_ready = '1;
    sample(); chk("t4_release", m_resp_valid, 4'b0001); advance();
    s_resp_valid = 1'b0;
    sample(); advance();
    sample(); chk("t4_next_grant", m_req_ready, 4'b0010); advance();
    s_resp_valid = 1'b1;
    sample(); advance();
    s_resp_valid = 1'b0;

    // Reset while a response is outstanding.
    do_reset();
    set_req(1, 32'h6000_0000, 1'b0, 32'h0, 4'h0);
    s_req_ready = 1'b1; m_resp_ready = '1;
    sample(); advance();
    sample(); advance();
    rst = 1'b1;
    sample(); advance();
    rst = 1'b0;
    set_req(0, 32'h7000_0000, 1'b0, 32'h0, 4'h0);
    set_req(1, 32'h6000_0000, 1'b0, 32'h0, 4'h0);
    sample();
    chk("t5_after_rst", {m_req_ready, m_resp_valid, s_req_valid, s_resp_ready, arb_err}, '0);
    advance();
    sample(); chk("t5_first_grant", m_req_ready, 4'b0001); advance();
    s_resp_valid = 1'b1; s_resp_rdata = 32'h0;
    sample(); advance();
    s_resp_valid = 1'b0;

`ifdef ARB_TIMEOUT_EN
    begin
      int pulses, first;
      do_reset();
      dut_grants.delete();
      set_req(0, 32'h8000_0100, 1'b0, 32'h0, 4'h0);
      set_req(1, 32'h8000_0200, 1'b0, 32'h0, 4'h0);
      s_req_ready = 1'b1; s_resp_valid = 1'b0; m_resp_ready = '1;
      pulses = 0; first = -1;
      for (int c = 0; c < 12; c++) begin
        sample();
        if (arb_err === 1'b1) begin
          pulses++;
          if (first < 0) first = c;
        end
        advance();
      end
      chk("t6_tmo_pulses", pulses, 1);
      chk("t6_tmo_cycle", first, 6);
      chk("t6_next_grant", (dut_grants.size() >= 2) ? dut_grants[1] : -1, 1);
    end
`endif

    // Randomized traffic on all masters with random slave and master stalls.
    do_reset();
    dut_grants.delete();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && !(owner == i && accepted) && $urandom_range(0, 2) == 0)
          set_req(i, AW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom), MW'($urandom));
      m_resp_ready = N'($urandom);
      s_req_ready  = ($urandom_range(0, 3) != 0);
      s_resp_valid = slv_busy && ($urandom_range(0, 1) == 1);
      s_resp_rdata = s_resp_valid ? slv_rdata : DW'($urandom);
      sample(); advance();
    end
    served = 0;
    foreach (dut_grants[k]) if (dut_grants[k] >= 0) served = served | (1 << dut_grants[k]);
    chk("rand_all_served", served, (1 << N) - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
